// File: rtl/trb_mem_arbiter.sv
// Shares one single-port trace RAM between a logger (alternating write/read slots)
// and a system readout port that wins the read slot whenever it has a request pending.
module trb_mem_arbiter #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK_I,
  input  logic              RST_NI,
  input  logic              ENABLE_I,
  input  logic              CLEAR_I,
  output logic              RW_TURN_O,
  output logic              WRITE_ALLOW_O,
  output logic              READ_ALLOW_O,
  input  logic              LOG_WRITE_I,
  input  logic [ADDR_W-1:0] LOG_WPTR_I,
  input  logic [WIDTH-1:0]  LOG_WDATA_I,
  input  logic [ADDR_W-1:0] LOG_RPTR_I,
  output logic [WIDTH-1:0]  LOG_RDATA_O,
  input  logic              SYS_REQ_I,
  input  logic [ADDR_W-1:0] SYS_ADDR_I,
  output logic              SYS_GNT_O,
  output logic              SYS_VALID_O,
  output logic [WIDTH-1:0]  SYS_DATA_O,
  output logic              MEM_EN_O,
  output logic              MEM_WE_O,
  output logic [ADDR_W-1:0] MEM_ADDR_O,
  output logic [WIDTH-1:0]  MEM_WDATA_O,
  input  logic [WIDTH-1:0]  MEM_RDATA_I
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic              rw_turn_q, rw_turn_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pf_vld_q, pf_vld_d;
  logic [ADDR_W-1:0] pf_tag_q, pf_tag_d;
  logic [WIDTH-1:0]  log_rdata_q, log_rdata_d;
  logic              log_cap_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic              sys_vld_q;
  logic [WIDTH-1:0]  sys_data_q;

  logic run, wr_slot, rd_slot, sys_gnt, log_rd, wr_issue;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ENABLE_I) state_d = S_RUN;
      S_RUN:   if (!ENABLE_I) state_d = S_DRAIN;
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (CLEAR_I) state_d = S_IDLE;

    rw_turn_d = 1'b0;
    if (state_d == S_RUN) rw_turn_d = (state_q == S_RUN) ? ~rw_turn_q : 1'b1;
  end

  // System reads take the read slot (every IDLE cycle counts as one); DRAIN issues nothing.
  assign run      = (state_q == S_RUN);
  assign wr_slot  = run & rw_turn_q;
  assign rd_slot  = run & ~rw_turn_q;
  assign sys_gnt  = pend_q & ((state_q == S_IDLE) | rd_slot);
  assign log_rd   = rd_slot & ~pend_q;
  assign wr_issue = wr_slot & LOG_WRITE_I;

  assign MEM_EN_O    = sys_gnt | log_rd | wr_issue;
  assign MEM_WE_O    = wr_issue;
  assign MEM_ADDR_O  = wr_issue ? LOG_WPTR_I : (sys_gnt ? pend_addr_q : LOG_RPTR_I);
  assign MEM_WDATA_O = LOG_WDATA_I;

  always_comb begin
    pend_d      = pend_q ? ~sys_gnt : SYS_REQ_I;
    pend_addr_d = (!pend_q && SYS_REQ_I) ? SYS_ADDR_I : pend_addr_q;
    if (CLEAR_I) pend_d = 1'b0;

    pf_tag_d    = log_cap_q ? cap_addr_q : pf_tag_q;
    pf_vld_d    = log_cap_q | pf_vld_q;
    log_rdata_d = log_cap_q ? MEM_RDATA_I : log_rdata_q;
    // A write to the tag address invalidates, including a capture landing this cycle.
    if (wr_issue && (LOG_WPTR_I == pf_tag_d)) pf_vld_d = 1'b0;
    if (CLEAR_I) pf_vld_d = 1'b0;
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q     <= S_IDLE;
      rw_turn_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pf_vld_q    <= 1'b0;
      pf_tag_q    <= '0;
      log_rdata_q <= '0;
      log_cap_q   <= 1'b0;
      cap_addr_q  <= '0;
      sys_vld_q   <= 1'b0;
      sys_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rw_turn_q   <= rw_turn_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pf_vld_q    <= pf_vld_d;
      pf_tag_q    <= pf_tag_d;
      log_rdata_q <= log_rdata_d;
      log_cap_q   <= log_rd;
      cap_addr_q  <= LOG_RPTR_I;
      sys_vld_q   <= sys_gnt;
      if (sys_vld_q) sys_data_q <= MEM_RDATA_I;
    end
  end

  assign RW_TURN_O     = rw_turn_q;
  assign WRITE_ALLOW_O = wr_slot;
  assign READ_ALLOW_O  = rd_slot & pf_vld_q & (pf_tag_q == LOG_RPTR_I);
  assign LOG_RDATA_O   = log_rdata_q;
  assign SYS_GNT_O     = sys_gnt;
  assign SYS_VALID_O   = sys_vld_q;
  // Return data is shown straight from the RAM on the valid cycle, then held.
  assign SYS_DATA_O    = sys_vld_q ? MEM_RDATA_I : sys_data_q;

endmodule

// File: tb/tb_trb_mem_arbiter.sv
// Cycle-by-cycle directed vectors for trb_mem_arbiter against a behavioural single-port RAM.
module tb_trb_mem_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0, clear = 1'b0;
  logic          rw_turn, write_allow, read_allow;
  logic          log_write = 1'b0;
  logic [AW-1:0] log_wptr = '0, log_rptr = '0;
  logic [DW-1:0] log_wdata = '0, log_rdata;
  logic          sys_req = 1'b0;
  logic [AW-1:0] sys_addr = '0;
  logic          sys_gnt, sys_valid;
  logic [DW-1:0] sys_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trb_mem_arbiter #(.DEPTH(16), .WIDTH(DW), .ADDR_W(AW)) dut (
    .CLK_I(clk), .RST_NI(rst_n), .ENABLE_I(enable), .CLEAR_I(clear),
    .RW_TURN_O(rw_turn), .WRITE_ALLOW_O(write_allow), .READ_ALLOW_O(read_allow),
    .LOG_WRITE_I(log_write), .LOG_WPTR_I(log_wptr), .LOG_WDATA_I(log_wdata),
    .LOG_RPTR_I(log_rptr), .LOG_RDATA_O(log_rdata),
    .SYS_REQ_I(sys_req), .SYS_ADDR_I(sys_addr), .SYS_GNT_O(sys_gnt),
    .SYS_VALID_O(sys_valid), .SYS_DATA_O(sys_data),
    .MEM_EN_O(mem_en), .MEM_WE_O(mem_we), .MEM_ADDR_O(mem_addr),
    .MEM_WDATA_O(mem_wdata), .MEM_RDATA_I(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic          rst_n, en, clr, lw;
    logic [AW-1:0] wptr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] rptr;
    logic          sreq;
    logic [AW-1:0] saddr;
    logic          turn, wal, ral, men, mwe;
    logic [AW-1:0] maddr;
    logic          gnt, svld;
    logic [DW-1:0] sd, lrd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rs, int en, int clr, int lw, int wp, int wd, int rp,
                              int sr, int sa, int turn, int wal, int ral, int men,
                              int mwe, int ma, int gnt, int svld, int sd, int lrd);
    vec_t v;
    v.rst_n = 1'(rs);  v.en = 1'(en);   v.clr = 1'(clr);   v.lw = 1'(lw);
    v.wptr = 4'(wp);   v.wdata = 8'(wd); v.rptr = 4'(rp);   v.sreq = 1'(sr);
    v.saddr = 4'(sa);  v.turn = 1'(turn); v.wal = 1'(wal); v.ral = 1'(ral);
    v.men = 1'(men);   v.mwe = 1'(mwe); v.maddr = 4'(ma);  v.gnt = 1'(gnt);
    v.svld = 1'(svld); v.sd = 8'(sd);   v.lrd = 8'(lrd);
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
    mem[5] = 8'hA5;
    mem[9] = 8'h3C;

    //               rs en cl lw wp wd     rp sr sa | tn wa ra me we ma g  sv sd     lrd
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0,     0));     // R0 reset
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,     0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0,     0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,     5, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0,     0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,     5, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0,     0));     // first RUN: write slot
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,     5, 0, 0,   0, 0, 0, 1, 0, 5, 0, 0, 0,     0));     // prefetch 5
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,     5, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0,     0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,     5, 0, 0,   0, 0, 1, 1, 0, 5, 0, 0, 0,     'hA5));  // R6 read allowed
    tbl.push_back(mk(1, 1, 0, 1, 5, 'h5A,  5, 0, 0,   1, 1, 0, 1, 1, 5, 0, 0, 0,     'hA5));  // write tag addr
    tbl.push_back(mk(1, 1, 0, 1, 3, 'hFF,  5, 0, 0,   0, 0, 0, 1, 0, 5, 0, 0, 0,     'hA5));  // write in read slot ignored
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,     5, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0,     'hA5));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,     5, 0, 0,   0, 0, 1, 1, 0, 5, 0, 0, 0,     'h5A));  // R10 new data
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,     5, 1, 9,   1, 1, 0, 0, 0, 0, 0, 0, 0,     'h5A));  // sys req 9
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,     5, 1, 2,   0, 0, 1, 1, 0, 9, 1, 0, 0,     'h5A));  // grant, 2nd req ignored
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,     5, 0, 0,   1, 1, 0, 0, 0, 0, 0, 1, 'h3C,  'h5A));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,     9, 0, 0,   0, 0, 0, 1, 0, 9, 0, 0, 'h3C,  'h5A));  // last RUN, read 9
    tbl.push_back(mk(1, 0, 0, 1, 7, 'h11,  9, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 'h3C,  'h5A));  // DRAIN
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,     9, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 'h3C,  'h3C));  // drain return kept
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,     9, 1, 5,   0, 0, 0, 0, 0, 0, 0, 0, 'h3C,  'h3C));  // IDLE sys req
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,     9, 0, 0,   0, 0, 0, 1, 0, 5, 1, 0, 'h3C,  'h3C));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,     9, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 'h5A,  'h3C));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,     9, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 'h5A,  'h3C));  // R20 data held
    tbl.push_back(mk(1, 1, 1, 0, 0, 0,     9, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 'h5A,  'h3C));  // clear beats enable
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,     9, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 'h5A,  'h3C));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,     9, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 'h5A,  'h3C));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,     9, 0, 0,   0, 0, 0, 1, 0, 9, 0, 0, 'h5A,  'h3C));  // prefetch cleared
    tbl.push_back(mk(1, 1, 1, 0, 0, 0,     9, 1, 2,   1, 1, 0, 0, 0, 0, 0, 0, 'h5A,  'h3C));  // clear drops req
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,     9, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 'h5A,  'h3C));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,     3, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 'h5A,  'h3C));
    tbl.push_back(mk(1, 1, 0, 1, 3, 'h77,  3, 0, 0,   1, 1, 0, 1, 1, 3, 0, 0, 'h5A,  'h3C));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,     3, 0, 0,   0, 0, 0, 1, 0, 3, 0, 0, 'h5A,  'h3C));
    tbl.push_back(mk(0, 1, 0, 1, 4, 'h88,  3, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0,     0));     // R30 reset in write slot
    tbl.push_back(mk(0, 1, 0, 1, 4, 'h88,  3, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0,     0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,     3, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0,     0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,     3, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0,     0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,     3, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0,     0));

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      rst_n     = tbl[i].rst_n;
      enable    = tbl[i].en;
      clear     = tbl[i].clr;
      log_write = tbl[i].lw;
      log_wptr  = tbl[i].wptr;
      log_wdata = tbl[i].wdata;
      log_rptr  = tbl[i].rptr;
      sys_req   = tbl[i].sreq;
      sys_addr  = tbl[i].saddr;
      @(negedge clk);
      chk("rw_turn",     i, 8'(rw_turn),     8'(tbl[i].turn));
      chk("write_allow", i, 8'(write_allow), 8'(tbl[i].wal));
      chk("read_allow",  i, 8'(read_allow),  8'(tbl[i].ral));
      chk("mem_en",      i, 8'(mem_en),      8'(tbl[i].men));
      chk("mem_we",      i, 8'(mem_we),      8'(tbl[i].mwe));
      if (tbl[i].men) chk("mem_addr", i, 8'(mem_addr), 8'(tbl[i].maddr));
      if (tbl[i].mwe) chk("mem_wdata", i, mem_wdata, tbl[i].wdata);
      chk("sys_gnt",     i, 8'(sys_gnt),     8'(tbl[i].gnt));
      chk("sys_valid",   i, 8'(sys_valid),   8'(tbl[i].svld));
      chk("sys_data",    i, sys_data,        tbl[i].sd);
      chk("log_rdata",   i, log_rdata,       tbl[i].lrd);
    end

    @(negedge clk);
    chk("mem3_written",        99, mem[3], 8'h77);
    chk("mem4_no_write_reset", 99, mem[4], 8'h14);
    chk("mem7_no_write_drain", 99, mem[7], 8'h17);
    chk("mem5_written",        99, mem[5], 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
